// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run controller.
// Holds the FSM state encodings, the default parameter values used by
// run_controller, and a saturating 16-bit increment helper.
package run_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_RUN   = 3'd2;
  localparam state_t ST_DUMP  = 3'd3;
  localparam state_t ST_ERROR = 3'd4;

  localparam logic [7:0]  DEF_LOAD_BASE = 8'd0;
  localparam int          DEF_LOAD_LEN  = 64;
  localparam logic [7:0]  DEF_DUMP_BASE = 8'd64;
  localparam int          DEF_DUMP_LEN  = 64;
  localparam logic [15:0] DEF_TIMEOUT   = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/run_controller_dump_stage.sv
// dump_stage: single output register for the result byte stream.
// Ports:
//   clk, reset            clock and asynchronous active-low reset
//   load                  capture load_data/load_last this edge
//   load_data, load_last  byte fetched from data_mem and its last flag
//   out_ready             downstream ready
//   out_valid, out_data, out_last  registered stream outputs
// The controller only asserts load when the register is empty or being
// drained, so a captured byte is never overwritten before acceptance.
module dump_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       load_last,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= 8'd0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q & valid_q;

endmodule

// File: rtl/run_controller.sv
// run_controller: sequences a processor run.
// On start it preloads LOAD_LEN bytes from the load stream into data_mem,
// releases the processor from reset until core_done (or a RUN-cycle
// timeout), then streams DUMP_LEN bytes of data_mem out on the dump stream.
// Ports:
//   clk, reset                         clock, asynchronous active-low reset
//   start                              begin a load/run/dump sequence
//   load_valid/load_ready/load_data    preload byte stream
//   mem_sel                            1 = processor owns data_mem
//   mem_addr/mem_wen/mem_ren/mem_wdata controller-side data_mem port
//   mem_rdata                          combinational data_mem read data
//   core_reset, core_done              processor reset and done flag
//   dump_valid/dump_ready/dump_data/dump_last  result byte stream
//   busy, error, run_cycles            status
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter logic [7:0]  LOAD_BASE = DEF_LOAD_BASE,
  parameter int          LOAD_LEN  = DEF_LOAD_LEN,
  parameter logic [7:0]  DUMP_BASE = DEF_DUMP_BASE,
  parameter int          DUMP_LEN  = DEF_DUMP_LEN,
  parameter logic [15:0] TIMEOUT   = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [7:0]  load_data,
  output logic        mem_sel,
  output logic [7:0]  mem_addr,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        core_reset,
  input  logic        core_done,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [7:0]  dump_data,
  output logic        dump_last,
  output logic        busy,
  output logic        error,
  output logic [15:0] run_cycles
);

  // cnt is 9 bits so a full 256-byte transfer can be counted to its end.
  localparam logic [8:0] LOAD_LAST  = 9'(LOAD_LEN - 1);
  localparam logic [8:0] DUMP_END   = 9'(DUMP_LEN);
  localparam logic [8:0] DUMP_LAST  = 9'(DUMP_LEN - 1);
  localparam bit         LOAD_EMPTY = (LOAD_LEN == 0);

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [15:0] run_cycles_q, run_cycles_d;
  logic        load_fire;
  logic        fetch;
  logic        dump_done;

  // A dump fetch refills the output register whenever it is empty or
  // being drained this cycle, giving one byte per cycle under full ready.
  always_comb begin
    load_fire = (state_q == ST_LOAD) && load_valid;
    fetch     = (state_q == ST_DUMP) && (!dump_valid || dump_ready) && (cnt_q < DUMP_END);
    dump_done = (state_q == ST_DUMP) && dump_valid && dump_ready && dump_last;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_cycles_d = run_cycles_q;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          cnt_d = 9'd0;
          if (LOAD_EMPTY) begin
            state_d      = ST_RUN;
            run_cycles_d = 16'd0;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (load_fire) begin
          cnt_d = cnt_q + 9'd1;
          if (cnt_q == LOAD_LAST) begin
            state_d      = ST_RUN;
            run_cycles_d = 16'd0;
          end
        end
      end
      ST_RUN: begin
        // core_done wins over a timeout landing on the same cycle.
        run_cycles_d = sat_inc16(run_cycles_q);
        if (core_done) begin
          state_d = ST_DUMP;
          cnt_d   = 9'd0;
        end else if (run_cycles_d == TIMEOUT) begin
          state_d = ST_ERROR;
        end
      end
      ST_DUMP: begin
        if (fetch) begin
          cnt_d = cnt_q + 9'd1;
        end
        if (dump_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 9'd0;
      run_cycles_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  // Address arithmetic is 8-bit so both windows wrap modulo 256.
  always_comb begin
    load_ready = (state_q == ST_LOAD);
    mem_wen    = load_fire;
    mem_ren    = fetch;
    mem_wdata  = load_fire ? load_data : 8'd0;
    mem_addr   = 8'd0;
    if (state_q == ST_LOAD) begin
      mem_addr = LOAD_BASE + cnt_q[7:0];
    end else if (state_q == ST_DUMP) begin
      mem_addr = DUMP_BASE + cnt_q[7:0];
    end
    mem_sel    = (state_q == ST_RUN);
    core_reset = (state_q != ST_RUN);
    busy       = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_DUMP);
    error      = (state_q == ST_ERROR);
  end

  assign run_cycles = run_cycles_q;

  dump_stage u_dump_stage (
    .clk       (clk),
    .reset     (reset),
    .load      (fetch),
    .load_data (mem_rdata),
    .load_last (cnt_q == DUMP_LAST),
    .out_ready (dump_ready),
    .out_valid (dump_valid),
    .out_data  (dump_data),
    .out_last  (dump_last)
  );

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter LOAD_BASE, default 8'd0: first data_mem address written during preload.
REQ-002 Parameter LOAD_LEN, default 64: bytes preloaded, 0..256.
REQ-003 Parameter DUMP_BASE, default 8'd64: first data_mem address read during dump.
REQ-004 Parameter DUMP_LEN, default 64: bytes dumped, 1..256.
REQ-005 Parameter TIMEOUT, default 16'hFFFF: maximum RUN cycles before error.
REQ-006 clk  in  1  single system clock.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle request to begin load/run/dump.
REQ-009 load_valid / load_ready / load_data  in / out / in  1/1/8  preload byte stream.
REQ-010 mem_sel  out  1  1 = processor owns data_mem port; 0 = controller owns it.
REQ-011 mem_addr / mem_wen / mem_ren / mem_wdata  out  8/1/1/8  controller-side data_mem port.
REQ-012 mem_rdata  in  8  data_mem read data, combinational from mem_addr.
REQ-013 core_reset  out  1  active-high reset to processor top.
REQ-014 core_done  in  1  processor done/halt flag.
REQ-015 dump_valid / dump_ready / dump_data / dump_last  out / in / out / out  1/1/8/1  result byte stream.
REQ-016 busy, error  out  1 each  status flags.
REQ-017 run_cycles  out  16  RUN-cycle count of the most recent run.

Function
REQ-018 FSM states are IDLE, LOAD, RUN, DUMP, ERROR.
REQ-019 IDLE: core_reset=1, mem_sel=0, busy=0; start -> LOAD with byte counter cnt=0 (LOAD_LEN=0 -> RUN directly).
REQ-020 start is ignored in LOAD, RUN and DUMP.
REQ-021 LOAD: load_ready=1; each cycle with load_valid&&load_ready drives mem_wen=1, mem_addr=LOAD_BASE+cnt (mod 256), mem_wdata=load_data, and increments cnt.
REQ-022 Acceptance of byte LOAD_LEN-1 transitions to RUN on the next edge; mem_wen is 0 in all other states.
REQ-023 RUN: core_reset=0, mem_sel=1, run_cycles cleared on entry and incremented every RUN cycle, saturating at 16'hFFFF.
REQ-024 core_done=1 in RUN -> DUMP next edge; core_reset is reasserted from the first DUMP cycle.
REQ-025 If run_cycles reaches TIMEOUT with core_done=0 -> ERROR; core_done on that same cycle takes priority (-> DUMP).
REQ-026 DUMP: mem_sel=0; a byte fetch (mem_ren=1, mem_addr=DUMP_BASE+cnt mod 256) occurs in any cycle where !dump_valid || dump_ready and bytes remain; fetched mem_rdata is registered into dump_data.
REQ-027 Dump latency: first dump_valid one cycle after DUMP entry; sustained throughput one byte/cycle while dump_ready=1.
REQ-028 dump_data and dump_last stay stable while dump_valid && !dump_ready.
REQ-029 dump_last=1 exactly with byte DUMP_LEN-1; its acceptance -> IDLE, dump_valid=0.
REQ-030 ERROR: error=1, core_reset=1, busy=0, no memory access; start -> LOAD and clears error.
REQ-031 busy=1 in LOAD, RUN, DUMP.

Reset
REQ-032 reset=0 asynchronously forces IDLE, cnt=0, core_reset=1, mem_sel=0, mem_wen=0, mem_ren=0, load_ready=0, dump_valid=0, dump_last=0, dump_data=0, error=0, run_cycles=0.
REQ-033 Reset asserted mid-LOAD/RUN/DUMP abandons the operation; no partial stream resumes after release.

Structure
REQ-034 State enum and default parameter constants reside in shared package run_ctrl_pkg.
REQ-035 The dump output register with valid/ready hold logic is sub-module dump_stage; everything else is flat.

Verification
REQ-036 start, LOAD_LEN=4 bytes 11,22,33,44 with load_valid gaps -> writes to addr 0..3 exactly once each, RUN entered after byte 4.
REQ-037 core_done raised after 10 RUN cycles, dump_ready=1 -> run_cycles=10, DUMP_LEN bytes from addr 64.. consecutive cycles, dump_last on final byte, back to IDLE.
REQ-038 dump_ready toggled 1/0 randomly -> dump_data stable when stalled, no byte lost or duplicated, address wraps 255->0 with DUMP_BASE=250, DUMP_LEN=10.
REQ-039 TIMEOUT=20, core_done never asserted -> ERROR after 20 RUN cycles, error=1, core_reset=1; then start -> LOAD, error=0.
REQ-040 reset pulled low mid-DUMP and mid-LOAD -> immediate IDLE outputs per REQ-032; start during RUN ignored.
